haze_frame_ctrl: RTL and testbench

Two-pass frame sequencer for the haze-removal pipeline. Pass 1 streams the frame's 3x3 windows into the atmospheric light estimator and waits for its pipeline to drain. It then latches the estimator's A and reciprocal-A results. Pass 2 rewinds the frame source and streams the frame through the recovery datapath using the latched values. It also clears the estimator between frames, because the estimator's done flag is sticky.

---
 rtl/haze_pkg.sv | 25 ++
 rtl/haze_frame_ctrl_if.sv | 32 +++
 rtl/haze_ctrl_wdt.sv | 25 ++
 rtl/haze_frame_ctrl.sv | 118 +++++++++++
 tb/tb_haze_frame_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/haze_pkg.sv
// Shared types and constants for the haze-removal frame sequencer.
package haze_pkg;

  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;
  localparam int A_W       = 8;
  localparam int Q16_W     = 16;

  function automatic int pix_cnt_width(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

  localparam int PIX_CNT_W = pix_cnt_width(IMG_W_DEF, IMG_H_DEF);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    ALE_PASS = 3'd2,
    DRAIN    = 3'd3,
    LATCH    = 3'd4,
    REC_PASS = 3'd5,
    DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/haze_frame_ctrl_if.sv
// Streaming bus between the frame sequencer, frame source, estimator and recovery path.
interface haze_frame_ctrl_if;
  import haze_pkg::*;

  logic             src_valid;
  logic             src_ready;
  logic             src_restart;
  logic             ale_rst;
  logic             ale_valid;
  logic             ale_done;
  logic [A_W-1:0]   ale_a_r, ale_a_g, ale_a_b;
  logic [Q16_W-1:0] ale_inv_a_r, ale_inv_a_g, ale_inv_a_b;
  logic             rec_valid;
  logic             rec_ready;
  logic [A_W-1:0]   a_r, a_g, a_b;
  logic [Q16_W-1:0] inv_a_r, inv_a_g, inv_a_b;

  modport master (
    input  src_valid, ale_done, ale_a_r, ale_a_g, ale_a_b,
           ale_inv_a_r, ale_inv_a_g, ale_inv_a_b, rec_ready,
    output src_ready, src_restart, ale_rst, ale_valid, rec_valid,
           a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b
  );

  modport slave (
    output src_valid, ale_done, ale_a_r, ale_a_g, ale_a_b,
           ale_inv_a_r, ale_inv_a_g, ale_inv_a_b, rec_ready,
    input  src_ready, src_restart, ale_rst, ale_valid, rec_valid,
           a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b
  );

endinterface

// File: rtl/haze_ctrl_wdt.sv
// Consecutive stall-cycle counter; trip fires on the LIMIT-th non-accept cycle of a pass.
module haze_ctrl_wdt #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic accept,
  output logic trip
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || !en || accept) begin
      stall_cnt <= '0;
    end else if (stall_cnt != CNT_W'(LIMIT)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign trip = en && !accept && (stall_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/haze_frame_ctrl.sv
// Two-pass frame sequencer: estimator pass, drain/latch of A and Inv_A, recovery pass.
// Optional stall watchdog enabled by defining HAZE_CTRL_WDT_EN.
module haze_frame_ctrl
  import haze_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int ALE_LAT   = 2,
  parameter int WDT_LIMIT = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  haze_frame_ctrl_if.master  bus,
  output logic               busy,
  output logic               frame_done,
  output logic               err
);
  localparam int N   = IMG_W * IMG_H;
  localparam int PCW = pix_cnt_width(IMG_W, IMG_H);
  localparam int DCW = (ALE_LAT > 1) ? $clog2(ALE_LAT) : 1;

  state_t         state, state_nxt;
  logic [PCW-1:0] pix_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           accept, last_pix, last_drain, wdt_trip;

  assign accept     = bus.src_valid && bus.src_ready;
  assign last_pix   = accept && (pix_cnt == PCW'(N - 1));
  assign last_drain = (drain_cnt == DCW'(ALE_LAT - 1));

`ifdef HAZE_CTRL_WDT_EN
  haze_ctrl_wdt #(.LIMIT(WDT_LIMIT)) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .en     ((state == ALE_PASS) || (state == REC_PASS)),
    .accept (accept),
    .trip   (wdt_trip)
  );
`else
  logic [31:0] unused_wdt_limit;
  assign unused_wdt_limit = WDT_LIMIT;
  assign wdt_trip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.src_ready = 1'b0;
    bus.ale_valid = 1'b0;
    bus.rec_valid = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = CLR;
      CLR:      state_nxt = ALE_PASS;
      ALE_PASS: begin
        bus.src_ready = 1'b1;
        bus.ale_valid = bus.src_valid;
        if (wdt_trip)      state_nxt = IDLE;
        else if (last_pix) state_nxt = DRAIN;
      end
      DRAIN:    if (last_drain) state_nxt = bus.ale_done ? LATCH : IDLE;
      LATCH:    state_nxt = REC_PASS;
      REC_PASS: begin
        bus.src_ready = bus.rec_ready;
        bus.rec_valid = bus.src_valid && bus.rec_ready;
        if (wdt_trip)      state_nxt = IDLE;
        else if (last_pix) state_nxt = DONE;
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy            = (state != IDLE);
  assign frame_done      = (state == DONE);
  assign bus.ale_rst     = (state == CLR);
  assign bus.src_restart = (state == CLR) || (state == LATCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt   <= '0;
      drain_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (state == CLR || state == LATCH)                        pix_cnt <= '0;
      else if ((state == ALE_PASS || state == REC_PASS) && accept) pix_cnt <= pix_cnt + PCW'(1);
      drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
      if (state == CLR)
        err <= 1'b0;
      else if ((state == DRAIN && last_drain && !bus.ale_done) || wdt_trip)
        err <= 1'b1;
    end
  end

  // Estimator results are held across aborted frames; only LATCH or reset changes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.a_r     <= '0;
      bus.a_g     <= '0;
      bus.a_b     <= '0;
      bus.inv_a_r <= '0;
      bus.inv_a_g <= '0;
      bus.inv_a_b <= '0;
    end else if (state == LATCH) begin
      bus.a_r     <= bus.ale_a_r;
      bus.a_g     <= bus.ale_a_g;
      bus.a_b     <= bus.ale_a_b;
      bus.inv_a_r <= bus.ale_inv_a_r;
      bus.inv_a_g <= bus.ale_inv_a_g;
      bus.inv_a_b <= bus.ale_inv_a_b;
    end
  end

endmodule

// File: tb/tb_haze_frame_ctrl.sv
// Bench for haze_frame_ctrl with a 4x4 frame, ALE_LAT=2, WDT_LIMIT=8.
module tb_haze_frame_ctrl;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done, err;

  logic        src_on = 1'b0;
  logic        rr = 1'b1;
  logic        done_kill = 1'b0;
  logic [7:0]  m_a_r = 8'd200, m_a_g = 8'd180, m_a_b = 8'd160;
  logic [15:0] m_i_r = 16'h0147, m_i_g = 16'h016C, m_i_b = 16'h0199;
  int          ale_cnt = 0;
  int          src_idx = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int rel = 0;
  int ale_seen = 0, ale_first = -1, ale_last = -1;

  typedef struct { int cyc; int pix; } rec_exp_t;
  rec_exp_t rec_q[$];
  int       done_q[$];

  typedef struct {
    int          cyc;
    logic [6:0]  ctl;
    logic [7:0]  a_r;
    logic [15:0] inv_r;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  haze_frame_ctrl_if bus();

  haze_frame_ctrl #(.IMG_W(4), .IMG_H(4), .ALE_LAT(2), .WDT_LIMIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  assign bus.src_valid   = src_on;
  assign bus.rec_ready   = rr;
  assign bus.ale_done    = (ale_cnt >= N) && !done_kill;
  assign bus.ale_a_r     = m_a_r;
  assign bus.ale_a_g     = m_a_g;
  assign bus.ale_a_b     = m_a_b;
  assign bus.ale_inv_a_r = m_i_r;
  assign bus.ale_inv_a_g = m_i_g;
  assign bus.ale_inv_a_b = m_i_b;

  // Estimator and frame-source models
  always @(posedge clk) begin
    if (bus.ale_rst) ale_cnt <= 0;
    else if (bus.ale_valid) ale_cnt <= ale_cnt + 1;
    if (bus.src_restart) src_idx <= 0;
    else if (bus.src_valid && bus.src_ready) src_idx <= src_idx + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, rel);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rec_valid) begin
      chk("rec_expected", 32'(rec_q.size() > 0), 32'd1);
      if (rec_q.size() > 0) begin
        rec_exp_t e;
        e = rec_q.pop_front();
        chk("rec_cycle", rel, e.cyc);
        chk("rec_pix", src_idx, e.pix);
      end
    end
    if (frame_done) begin
      chk("done_expected", 32'(done_q.size() > 0), 32'd1);
      if (done_q.size() > 0) chk("done_cycle", rel, done_q.pop_front());
    end
    if (bus.ale_valid) begin
      ale_seen++;
      if (ale_first < 0) ale_first = rel;
      ale_last = rel;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic start_frame();
    ale_seen = 0; ale_first = -1; ale_last = -1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rel = 1;
    start = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (rel < c) step();
  endtask

  task automatic push_rec(input int first, input int stride, input int cnt);
    for (int i = 0; i < cnt; i++) rec_q.push_back('{first + i * stride, i});
  endtask

  task automatic check_tbl();
    for (int k = 0; k < 10; k++) begin
      if (tbl[k].cyc == rel) begin
        chk($sformatf("ctl_c%0d", rel),
            32'({busy, bus.ale_rst, bus.src_restart, bus.ale_valid,
                 bus.src_ready, bus.rec_valid, frame_done}), 32'(tbl[k].ctl));
        chk($sformatf("a_r_c%0d", rel), 32'(bus.a_r), 32'(tbl[k].a_r));
        chk($sformatf("inv_r_c%0d", rel), 32'(bus.inv_a_r), 32'(tbl[k].inv_r));
      end
    end
  endtask

  initial begin
    // {busy, ale_rst, src_restart, ale_valid, src_ready, rec_valid, frame_done}
    tbl[0] = '{1,  7'b1110000, 8'd0,   16'h0000};
    tbl[1] = '{2,  7'b1001100, 8'd0,   16'h0000};
    tbl[2] = '{17, 7'b1001100, 8'd0,   16'h0000};
    tbl[3] = '{18, 7'b1000000, 8'd0,   16'h0000};
    tbl[4] = '{19, 7'b1000000, 8'd0,   16'h0000};
    tbl[5] = '{20, 7'b1010000, 8'd0,   16'h0000};
    tbl[6] = '{21, 7'b1000110, 8'd200, 16'h0147};
    tbl[7] = '{36, 7'b1000110, 8'd200, 16'h0147};
    tbl[8] = '{37, 7'b1000001, 8'd200, 16'h0147};
    tbl[9] = '{38, 7'b0000000, 8'd200, 16'h0147};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 32'({busy, frame_done, err, bus.src_ready, bus.src_restart,
                        bus.ale_rst, bus.ale_valid, bus.rec_valid}), 32'd0);
    chk("rst_a", 32'({bus.a_r, bus.a_g, bus.a_b}), 32'd0);
    chk("rst_inv_rg", {bus.inv_a_r, bus.inv_a_g}, 32'd0);
    chk("rst_inv_b", 32'(bus.inv_a_b), 32'd0);
    rst = 1'b0;
    step();

    // Nominal frame
    src_on = 1'b1; rr = 1'b1;
    push_rec(21, 1, N);
    done_q.push_back(37);
    start_frame();
    check_tbl();
    while (rel < 38) begin
      step();
      check_tbl();
    end
    chk("ale_count", ale_seen, N);
    chk("ale_first", ale_first, 2);
    chk("ale_last", ale_last, 17);
    chk("a_gb", 32'({bus.a_g, bus.a_b}), 32'({8'd180, 8'd160}));
    chk("inv_gb", {bus.inv_a_g, bus.inv_a_b}, {16'h016C, 16'h0199});
    run_to(40);

    // Backpressure in recovery pass
    push_rec(21, 2, N);
    done_q.push_back(52);
    start_frame();
    while (rel < 54) begin
      step();
      rr = (rel >= 21 && rel <= 51) ? ((rel - 21) % 2 == 0) : 1'b1;
      #1;
      if (rel == 22 || rel == 23 || rel == 40 || rel == 51)
        chk($sformatf("bp_src_ready_c%0d", rel), 32'(bus.src_ready), 32'(rr));
    end
    rr = 1'b1;

    // Estimator never done: err, no latch, prior A kept
    m_a_r = 8'd1; m_a_g = 8'd2; m_a_b = 8'd3;
    m_i_r = 16'd4; m_i_g = 16'd5; m_i_b = 16'd6;
    done_kill = 1'b1;
    start_frame();
    run_to(20);
    chk("nd_err", 32'(err), 32'd1);
    chk("nd_busy", 32'(busy), 32'd0);
    chk("nd_restart", 32'(bus.src_restart), 32'd0);
    run_to(24);
    chk("nd_a_keep", 32'({bus.a_r, bus.a_g, bus.a_b}), 32'({8'd200, 8'd180, 8'd160}));
    chk("nd_inv_keep", 32'(bus.inv_a_r), 32'h0147);

    // Next start clears err; start during ALE_PASS ignored
    done_kill = 1'b0;
    m_a_r = 8'd10; m_a_g = 8'd20; m_a_b = 8'd30;
    m_i_r = 16'h1000; m_i_g = 16'h2000; m_i_b = 16'h3000;
    push_rec(21, 1, N);
    done_q.push_back(37);
    start_frame();
    run_to(3);
    chk("clr_err", 32'(err), 32'd0);
    run_to(5);
    start = 1'b1;
    step();
    start = 1'b0;
    run_to(38);
    chk("new_a_r", 32'(bus.a_r), 32'd10);
    chk("new_inv_b", 32'(bus.inv_a_b), 32'h3000);
    run_to(45);
    chk("ign_busy", 32'(busy), 32'd0);

    // Reset during recovery pass
    push_rec(21, 1, 5);
    start_frame();
    run_to(25);
    rst = 1'b1;
    step();
    chk("mid_rst_ctl", 32'({busy, frame_done, err, bus.src_ready, bus.src_restart,
                            bus.ale_rst, bus.ale_valid, bus.rec_valid}), 32'd0);
    chk("mid_rst_a", 32'({bus.a_r, bus.a_g, bus.a_b}), 32'd0);
    chk("mid_rst_inv", {bus.inv_a_r, bus.inv_a_b}, 32'd0);
    rst = 1'b0;
    step();

    // Source stalls after 5 accepts
    src_on = 1'b1;
    start_frame();
    run_to(7);
    src_on = 1'b0;
`ifdef HAZE_CTRL_WDT_EN
    run_to(14);
    chk("wdt_busy_pre", 32'(busy), 32'd1);
    run_to(16);
    chk("wdt_err", 32'(err), 32'd1);
    chk("wdt_busy", 32'(busy), 32'd0);
    run_to(30);
`else
    run_to(30);
    chk("nowdt_busy", 32'(busy), 32'd1);
    chk("nowdt_err", 32'(err), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif

    chk("rec_q_empty", rec_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
